// File: rtl/sram_bus_ctrl_if.sv
// sram_bus_ctrl_if: pipeline-side and SRAM-pad-side signals of the shared SRAM
// bus controller.
//   pipeline side : flush, inst_req/inst_addr -> inst_o/inst_valid,
//                   data_ce/data_we/data_addr/data_sel/data_wdata -> data_rdata/data_ready,
//                   stallreq_o
//   pad side      : sram_addr, sram_dq_o/sram_dq_oe/sram_dq_i, sram_ce_n,
//                   sram_oe_n, sram_we_n, sram_be_n
// modport slave is the controller. modport master is everything around it:
// the pipeline and the pad, which returns read data on sram_dq_i.
interface sram_bus_ctrl_if #(
  parameter int ADDR_W = 20
);
  logic              flush;
  logic              inst_req;
  logic [31:0]       inst_addr;
  logic [31:0]       inst_o;
  logic              inst_valid;
  logic              data_ce;
  logic              data_we;
  logic [31:0]       data_addr;
  logic [3:0]        data_sel;
  logic [31:0]       data_wdata;
  logic [31:0]       data_rdata;
  logic              data_ready;
  logic              stallreq_o;
  logic [ADDR_W-1:0] sram_addr;
  logic [31:0]       sram_dq_o;
  logic              sram_dq_oe;
  logic [31:0]       sram_dq_i;
  logic              sram_ce_n;
  logic              sram_oe_n;
  logic              sram_we_n;
  logic [3:0]        sram_be_n;

  modport slave (
    input  flush, inst_req, inst_addr, data_ce, data_we, data_addr, data_sel,
           data_wdata, sram_dq_i,
    output inst_o, inst_valid, data_rdata, data_ready, stallreq_o, sram_addr,
           sram_dq_o, sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n, sram_be_n
  );

  modport master (
    output flush, inst_req, inst_addr, data_ce, data_we, data_addr, data_sel,
           data_wdata, sram_dq_i,
    input  inst_o, inst_valid, data_rdata, data_ready, stallreq_o, sram_addr,
           sram_dq_o, sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n, sram_be_n
  );
endinterface

// File: rtl/sram_bus_ctrl.sv
// sram_bus_ctrl: multi-cycle controller for one asynchronous single-port SRAM.
// It is shared by instruction fetch and data load/store. Data accesses win
// arbitration. stallreq_o holds the pipeline until an access finishes.
// Ports:
//   clk, rst : system clock, asynchronous active-high reset
//   bus      : sram_bus_ctrl_if.slave (pipeline request/response + SRAM pads)
// Parameters: ADDR_W word-address width, RD_WAIT extra read wait cycles,
//             WE_PULSE write-strobe length in cycles.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | bus released, arbitrate data (first) vs. instruction request
// DRD     | data read in flight, cnt counts remaining wait cycles
// WSETUP  | write address/data/byte-enables set up, we_n still high
// WPULSE  | we_n low, cnt counts remaining strobe cycles
// WHOLD   | we_n high again, data/address held for hold time
// IRD     | instruction read in flight, cnt counts remaining wait cycles
// DONE    | bus released, one-cycle ready/valid pulse unless aborted
module sram_bus_ctrl #(
  parameter int ADDR_W   = 20,
  parameter int RD_WAIT  = 1,
  parameter int WE_PULSE = 1
) (
  input logic           clk,
  input logic           rst,
  sram_bus_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_DRD, S_WSETUP, S_WPULSE, S_WHOLD, S_IRD, S_DONE
  } state_t;

  state_t state, state_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic       abort;

  logic [ADDR_W-1:0] addr_nxt;
  logic [31:0]       dq_o_nxt, inst_o_nxt, rdata_nxt;
  logic              dq_oe_nxt, ce_n_nxt, oe_n_nxt, we_n_nxt;
  logic [3:0]        be_n_nxt;
  logic              ready_nxt, valid_nxt;
  logic              done_ok;

  // Byte-offset bits and bits above the SRAM window are not decoded, so
  // addresses wrap around the SRAM size.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.inst_addr[31:ADDR_W+2], bus.inst_addr[1:0],
                              bus.data_addr[31:ADDR_W+2], bus.data_addr[1:0]};

  // A flush in the final active cycle must also kill the pulse, because the
  // abort flag would only be set at that same edge.
  assign done_ok = !(abort || bus.flush);

  assign bus.stallreq_o = !rst && (state != S_DONE) &&
                          ((state != S_IDLE) || bus.data_ce || bus.inst_req);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= S_IDLE;
      cnt            <= 4'd0;
      abort          <= 1'b0;
      bus.sram_addr  <= '0;
      bus.sram_dq_o  <= 32'd0;
      bus.sram_dq_oe <= 1'b0;
      bus.sram_ce_n  <= 1'b1;
      bus.sram_oe_n  <= 1'b1;
      bus.sram_we_n  <= 1'b1;
      bus.sram_be_n  <= 4'hF;
      bus.inst_o     <= 32'd0;
      bus.data_rdata <= 32'd0;
      bus.inst_valid <= 1'b0;
      bus.data_ready <= 1'b0;
    end else begin
      state          <= state_nxt;
      cnt            <= cnt_nxt;
      if (state == S_DONE)
        abort <= 1'b0;
      else if (state != S_IDLE && bus.flush)
        abort <= 1'b1;
      bus.sram_addr  <= addr_nxt;
      bus.sram_dq_o  <= dq_o_nxt;
      bus.sram_dq_oe <= dq_oe_nxt;
      bus.sram_ce_n  <= ce_n_nxt;
      bus.sram_oe_n  <= oe_n_nxt;
      bus.sram_we_n  <= we_n_nxt;
      bus.sram_be_n  <= be_n_nxt;
      bus.inst_o     <= inst_o_nxt;
      bus.data_rdata <= rdata_nxt;
      bus.inst_valid <= valid_nxt;
      bus.data_ready <= ready_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    unique case (state)
      S_IDLE: begin
        if (bus.data_ce && bus.data_we) begin
          state_nxt = S_WSETUP;
        end else if (bus.data_ce) begin
          state_nxt = S_DRD;
          cnt_nxt   = 4'(RD_WAIT);
        end else if (bus.inst_req) begin
          state_nxt = S_IRD;
          cnt_nxt   = 4'(RD_WAIT);
        end
      end
      S_DRD, S_IRD: begin
        if (cnt != 4'd0) cnt_nxt = cnt - 4'd1;
        else             state_nxt = S_DONE;
      end
      S_WSETUP: begin
        state_nxt = S_WPULSE;
        cnt_nxt   = 4'(WE_PULSE - 1);
      end
      S_WPULSE: begin
        if (cnt != 4'd0) cnt_nxt = cnt - 4'd1;
        else             state_nxt = S_WHOLD;
      end
      S_WHOLD: state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Next values of the registered SRAM and response outputs; anything not
  // assigned below holds its current value.
  always_comb begin
    addr_nxt   = bus.sram_addr;
    dq_o_nxt   = bus.sram_dq_o;
    dq_oe_nxt  = bus.sram_dq_oe;
    ce_n_nxt   = bus.sram_ce_n;
    oe_n_nxt   = bus.sram_oe_n;
    we_n_nxt   = bus.sram_we_n;
    be_n_nxt   = bus.sram_be_n;
    inst_o_nxt = bus.inst_o;
    rdata_nxt  = bus.data_rdata;
    ready_nxt  = 1'b0;
    valid_nxt  = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (bus.data_ce && bus.data_we) begin
          addr_nxt  = bus.data_addr[ADDR_W+1:2];
          dq_o_nxt  = bus.data_wdata;
          dq_oe_nxt = 1'b1;
          ce_n_nxt  = 1'b0;
          oe_n_nxt  = 1'b1;
          we_n_nxt  = 1'b1;
          be_n_nxt  = ~bus.data_sel;
        end else if (bus.data_ce || bus.inst_req) begin
          addr_nxt  = bus.data_ce ? bus.data_addr[ADDR_W+1:2]
                                  : bus.inst_addr[ADDR_W+1:2];
          dq_oe_nxt = 1'b0;
          ce_n_nxt  = 1'b0;
          oe_n_nxt  = 1'b0;
          we_n_nxt  = 1'b1;
          be_n_nxt  = 4'h0;
        end
      end
      S_DRD, S_IRD: begin
        if (cnt == 4'd0) begin
          if (state == S_DRD) begin
            rdata_nxt = bus.sram_dq_i;
            ready_nxt = done_ok;
          end else begin
            inst_o_nxt = bus.sram_dq_i;
            valid_nxt  = done_ok;
          end
          ce_n_nxt = 1'b1;
          oe_n_nxt = 1'b1;
          be_n_nxt = 4'hF;
        end
      end
      S_WSETUP: we_n_nxt = 1'b0;
      S_WPULSE: if (cnt == 4'd0) we_n_nxt = 1'b1;
      S_WHOLD: begin
        ready_nxt = done_ok;
        dq_oe_nxt = 1'b0;
        ce_n_nxt  = 1'b1;
        oe_n_nxt  = 1'b1;
        we_n_nxt  = 1'b1;
        be_n_nxt  = 4'hF;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_sram_bus_ctrl.sv
module tb_sram_bus_ctrl;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sram_bus_ctrl_if #(.ADDR_W(20)) bus0 ();
  sram_bus_ctrl_if #(.ADDR_W(20)) bus1 ();

  sram_bus_ctrl #(.ADDR_W(20), .RD_WAIT(1), .WE_PULSE(1)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
  sram_bus_ctrl #(.ADDR_W(20), .RD_WAIT(3), .WE_PULSE(2)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;

  logic        tr_ready[32], tr_valid[32], tr_stall[32], tr_ce_n[32];
  logic        tr_oe_n[32], tr_we_n[32], tr_dq_oe[32];
  logic [3:0]  tr_be_n[32];
  logic [19:0] tr_addr[32];
  logic [31:0] tr_dq_o[32];
  logic [31:0] got;

  function automatic logic [15:0] vec(input logic a[32], input int n);
    logic [15:0] v = '0;
    for (int c = 0; c < n && c < 16; c++) v[c] = a[c];
    return v;
  endfunction

  // Record one sample per cycle (at negedge) and behave like the pipeline:
  // drop a request in the cycle after its ready/valid pulse.
  task automatic run(input bit s1, input int n);
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      if (s1) begin
        tr_ready[cyc] = bus1.data_ready;  tr_valid[cyc] = bus1.inst_valid;
        tr_stall[cyc] = bus1.stallreq_o;  tr_ce_n[cyc]  = bus1.sram_ce_n;
        tr_oe_n[cyc]  = bus1.sram_oe_n;   tr_we_n[cyc]  = bus1.sram_we_n;
        tr_dq_oe[cyc] = bus1.sram_dq_oe;  tr_be_n[cyc]  = bus1.sram_be_n;
        tr_addr[cyc]  = bus1.sram_addr;   tr_dq_o[cyc]  = bus1.sram_dq_o;
      end else begin
        tr_ready[cyc] = bus0.data_ready;  tr_valid[cyc] = bus0.inst_valid;
        tr_stall[cyc] = bus0.stallreq_o;  tr_ce_n[cyc]  = bus0.sram_ce_n;
        tr_oe_n[cyc]  = bus0.sram_oe_n;   tr_we_n[cyc]  = bus0.sram_we_n;
        tr_dq_oe[cyc] = bus0.sram_dq_oe;  tr_be_n[cyc]  = bus0.sram_be_n;
        tr_addr[cyc]  = bus0.sram_addr;   tr_dq_o[cyc]  = bus0.sram_dq_o;
      end
      @(posedge clk);
      #1;
      if (tr_ready[cyc]) begin if (s1) bus1.data_ce = 1'b0; else bus0.data_ce = 1'b0; end
      if (tr_valid[cyc]) begin if (s1) bus1.inst_req = 1'b0; else bus0.inst_req = 1'b0; end
      cyc++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus0.inst_req = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    n_checks++;
    if (bus0.stallreq_o !== 1'b0) begin n_fail++; $display("FAIL rst_stall: got %b want 0", bus0.stallreq_o); end
    got = {21'd0, bus0.sram_ce_n, bus0.sram_oe_n, bus0.sram_we_n, bus0.sram_be_n, bus0.sram_dq_oe, bus0.data_ready, bus0.inst_valid};
    n_checks++;
    if (got !== 32'h000003F8) begin n_fail++; $display("FAIL rst_ctrl: got %h want 000003f8", got); end
    n_checks++;
    if ({bus0.sram_addr, bus0.sram_dq_o, bus0.inst_o, bus0.data_rdata} !== '0) begin
      n_fail++; $display("FAIL rst_data: got %h %h %h %h want 0", bus0.sram_addr, bus0.sram_dq_o, bus0.inst_o, bus0.data_rdata);
    end
    bus0.inst_req = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_read();
    cyc = 0;
    bus0.sram_dq_i = 32'hDEADBEEF; bus0.data_addr = 32'h10; bus0.data_we = 1'b0; bus0.data_ce = 1'b1;
    run(0, 6);
    got = 32'(vec(tr_ready, 6)); n_checks++;
    if (got !== 32'b001000) begin n_fail++; $display("FAIL rd_ready: got %b want 001000", got); end
    got = 32'(vec(tr_stall, 6)); n_checks++;
    if (got !== 32'b000111) begin n_fail++; $display("FAIL rd_stall: got %b want 000111", got); end
    got = 32'(~vec(tr_oe_n, 6) & 16'h3F); n_checks++;
    if (got !== 32'b000110) begin n_fail++; $display("FAIL rd_oe_low: got %b want 000110", got); end
    got = 32'(~vec(tr_ce_n, 6) & 16'h3F); n_checks++;
    if (got !== 32'b000110) begin n_fail++; $display("FAIL rd_ce_low: got %b want 000110", got); end
    got = {tr_addr[1], tr_be_n[1], 7'd0, tr_dq_oe[1]}; n_checks++;
    if (got !== {20'h4, 4'h0, 8'h0}) begin n_fail++; $display("FAIL rd_addr_be: got %h want 00004000", got); end
    n_checks++;
    if (bus0.data_rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL rd_data: got %h want deadbeef", bus0.data_rdata); end
  endtask

  task automatic test_byte_store();
    cyc = 0;
    bus0.data_addr = 32'h8; bus0.data_sel = 4'b0100; bus0.data_wdata = 32'h00AB0000;
    bus0.data_we = 1'b1; bus0.data_ce = 1'b1;
    run(0, 6);
    bus0.data_we = 1'b0;
    got = 32'(vec(tr_ready, 6)); n_checks++;
    if (got !== 32'b010000) begin n_fail++; $display("FAIL wr_ready: got %b want 010000", got); end
    got = 32'(~vec(tr_we_n, 6) & 16'h3F); n_checks++;
    if (got !== 32'b000100) begin n_fail++; $display("FAIL wr_we_low: got %b want 000100", got); end
    got = 32'(vec(tr_dq_oe, 6)); n_checks++;
    if (got !== 32'b001110) begin n_fail++; $display("FAIL wr_dq_oe: got %b want 001110", got); end
    got = 32'(vec(tr_stall, 6)); n_checks++;
    if (got !== 32'b001111) begin n_fail++; $display("FAIL wr_stall: got %b want 001111", got); end
    got = 32'(~vec(tr_oe_n, 6) & 16'h3F); n_checks++;
    if (got !== 32'd0) begin n_fail++; $display("FAIL wr_oe_low: got %b want 000000", got); end
    got = {tr_addr[1], tr_be_n[1], tr_be_n[3], 4'd0}; n_checks++;
    if (got !== {20'h2, 4'b1011, 4'b1011, 4'd0}) begin n_fail++; $display("FAIL wr_addr_be: got %h want 00002bb0", got); end
    n_checks++;
    if (tr_dq_o[3] !== 32'h00AB0000) begin n_fail++; $display("FAIL wr_dq_o: got %h want 00ab0000", tr_dq_o[3]); end
  endtask

  task automatic test_conflict();
    cyc = 0;
    bus0.sram_dq_i = 32'h12345678; bus0.data_addr = 32'h20; bus0.inst_addr = 32'h40;
    bus0.data_ce = 1'b1; bus0.inst_req = 1'b1;
    run(0, 9);
    got = 32'(vec(tr_ready, 9)); n_checks++;
    if (got !== 32'b000001000) begin n_fail++; $display("FAIL cf_ready: got %b want 000001000", got); end
    got = 32'(vec(tr_valid, 9)); n_checks++;
    if (got !== 32'b010000000) begin n_fail++; $display("FAIL cf_valid: got %b want 010000000", got); end
    got = 32'(vec(tr_stall, 9)); n_checks++;
    if (got !== 32'b001110111) begin n_fail++; $display("FAIL cf_stall: got %b want 001110111", got); end
    got = {6'd0, tr_addr[1][12:0], tr_addr[5][12:0]}; n_checks++;
    if (got !== {6'd0, 13'h8, 13'h10}) begin n_fail++; $display("FAIL cf_addr: got %h want %h", got, {6'd0, 13'h8, 13'h10}); end
    n_checks++;
    if (bus0.inst_o !== 32'h12345678) begin n_fail++; $display("FAIL cf_inst: got %h want 12345678", bus0.inst_o); end
  endtask

  task automatic test_flush();
    cyc = 0;
    bus0.sram_dq_i = 32'h11112222; bus0.inst_addr = 32'h100; bus0.inst_req = 1'b1;
    run(0, 1);
    bus0.flush = 1'b1; bus0.inst_req = 1'b0;
    run(0, 1);
    bus0.flush = 1'b0;
    run(0, 4);
    got = 32'(vec(tr_valid, 6)); n_checks++;
    if (got !== 32'd0) begin n_fail++; $display("FAIL fl_valid: got %b want 000000", got); end
    got = 32'(~vec(tr_oe_n, 6) & 16'h3F); n_checks++;
    if (got !== 32'b000110) begin n_fail++; $display("FAIL fl_oe_low: got %b want 000110", got); end
    got = 32'(vec(tr_stall, 6)); n_checks++;
    if (got !== 32'b000111) begin n_fail++; $display("FAIL fl_stall: got %b want 000111", got); end
    cyc = 0;
    bus0.sram_dq_i = 32'hCAFEF00D; bus0.inst_addr = 32'h104; bus0.inst_req = 1'b1;
    run(0, 5);
    got = 32'(vec(tr_valid, 5)); n_checks++;
    if (got !== 32'b01000) begin n_fail++; $display("FAIL fl_next_valid: got %b want 01000", got); end
    n_checks++;
    if (bus0.inst_o !== 32'hCAFEF00D || tr_addr[1] !== 20'h41) begin
      n_fail++; $display("FAIL fl_next_data: got %h @%h want cafef00d @00041", bus0.inst_o, tr_addr[1]);
    end
  endtask

  task automatic test_idle_flush_wrap();
    cyc = 0;
    bus0.flush = 1'b1; bus0.sram_dq_i = 32'h0BADF00D; bus0.data_addr = 32'hFFF00004;
    bus0.data_we = 1'b0; bus0.data_ce = 1'b1;
    run(0, 1);
    bus0.flush = 1'b0;
    run(0, 4);
    got = 32'(vec(tr_ready, 5)); n_checks++;
    if (got !== 32'b01000) begin n_fail++; $display("FAIL wrap_ready: got %b want 01000", got); end
    n_checks++;
    if (tr_addr[1] !== 20'hC0001) begin n_fail++; $display("FAIL wrap_addr: got %h want c0001", tr_addr[1]); end
    n_checks++;
    if (bus0.data_rdata !== 32'h0BADF00D) begin n_fail++; $display("FAIL wrap_data: got %h want 0badf00d", bus0.data_rdata); end
  endtask

  task automatic test_reset_mid_write();
    cyc = 0;
    bus0.data_addr = 32'hC; bus0.data_sel = 4'hF; bus0.data_wdata = 32'h55AA55AA;
    bus0.data_we = 1'b1; bus0.data_ce = 1'b1;
    run(0, 2);
    n_checks++;
    if (bus0.sram_we_n !== 1'b0) begin n_fail++; $display("FAIL rmw_in_pulse: got we_n=%b want 0", bus0.sram_we_n); end
    rst = 1'b1;
    #1;
    got = {28'd0, bus0.sram_we_n, bus0.sram_dq_oe, bus0.stallreq_o, bus0.sram_ce_n}; n_checks++;
    if (got !== 32'b1001) begin n_fail++; $display("FAIL rmw_async: got we_n,dq_oe,stall,ce_n=%b want 1001", got[3:0]); end
    bus0.data_ce = 1'b0; bus0.data_we = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    cyc = 0;
    run(0, 3);
    got = {13'd0, vec(tr_stall, 3)[2:0], 13'd0, vec(tr_ready, 3)[2:0]}; n_checks++;
    if (got !== 32'd0) begin n_fail++; $display("FAIL rmw_idle: got %h want 0", got); end
  endtask

  task automatic test_param_sweep();
    cyc = 0;
    bus1.sram_dq_i = 32'hA5A55A5A; bus1.data_addr = 32'h30; bus1.data_we = 1'b0; bus1.data_ce = 1'b1;
    run(1, 8);
    got = 32'(vec(tr_ready, 8)); n_checks++;
    if (got !== 32'b00100000) begin n_fail++; $display("FAIL ps_rd_ready: got %b want 00100000", got); end
    got = 32'(~vec(tr_oe_n, 8) & 16'hFF); n_checks++;
    if (got !== 32'b00011110) begin n_fail++; $display("FAIL ps_rd_oe_low: got %b want 00011110", got); end
    n_checks++;
    if (bus1.data_rdata !== 32'hA5A55A5A) begin n_fail++; $display("FAIL ps_rd_data: got %h want a5a55a5a", bus1.data_rdata); end
    cyc = 0;
    bus1.data_addr = 32'h34; bus1.data_sel = 4'b0011; bus1.data_wdata = 32'h0000BEEF;
    bus1.data_we = 1'b1; bus1.data_ce = 1'b1;
    run(1, 8);
    bus1.data_we = 1'b0;
    got = 32'(vec(tr_ready, 8)); n_checks++;
    if (got !== 32'b00100000) begin n_fail++; $display("FAIL ps_wr_ready: got %b want 00100000", got); end
    got = 32'(~vec(tr_we_n, 8) & 16'hFF); n_checks++;
    if (got !== 32'b00001100) begin n_fail++; $display("FAIL ps_wr_we_low: got %b want 00001100", got); end
    got = 32'(vec(tr_dq_oe, 8)); n_checks++;
    if (got !== 32'b00011110) begin n_fail++; $display("FAIL ps_wr_dq_oe: got %b want 00011110", got); end
    n_checks++;
    if (tr_be_n[2] !== 4'b1100 || tr_addr[2] !== 20'hD) begin
      n_fail++; $display("FAIL ps_wr_be_addr: got %b @%h want 1100 @0000d", tr_be_n[2], tr_addr[2]);
    end
  endtask

  initial begin
    rst = 1'b1;
    bus0.flush = 1'b0; bus0.inst_req = 1'b0; bus0.inst_addr = '0; bus0.data_ce = 1'b0;
    bus0.data_we = 1'b0; bus0.data_addr = '0; bus0.data_sel = 4'hF; bus0.data_wdata = '0;
    bus0.sram_dq_i = '0;
    bus1.flush = 1'b0; bus1.inst_req = 1'b0; bus1.inst_addr = '0; bus1.data_ce = 1'b0;
    bus1.data_we = 1'b0; bus1.data_addr = '0; bus1.data_sel = 4'hF; bus1.data_wdata = '0;
    bus1.sram_dq_i = '0;
    test_reset();
    test_read();
    test_byte_store();
    test_conflict();
    test_flush();
    test_idle_flush_wrap();
    test_reset_mid_write();
    test_param_sweep();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
